// File: rtl/gobou_serial_stream.sv
`default_nettype none
// ==== gobou_serial_stream : CORE-lane vector to serial beat stream, one-deep pending buffer ====
// ==== rev 1.0 ==================================================================================
module gobou_serial_stream #(
  parameter int DWIDTH = 16,
  parameter int CORE   = 16,
  parameter int LWIDTH = $clog2(CORE + 1)
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] in_data [CORE-1:0],
  input  logic [LWIDTH-1:0]        in_len,
  input  logic                     in_rev,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [LWIDTH-1:0] C_CORE_LEN = LWIDTH'(CORE);
  localparam logic [LWIDTH-1:0] C_ONE      = LWIDTH'(1);

  logic [0:0]               r_state;
  logic signed [DWIDTH-1:0] r_act_data [CORE-1:0];
  logic [LWIDTH-1:0]        r_act_len;
  logic                     r_act_rev;
  logic [LWIDTH-1:0]        r_cnt;
  logic signed [DWIDTH-1:0] r_pend_data [CORE-1:0];
  logic [LWIDTH-1:0]        r_pend_len;
  logic                     r_pend_rev;
  logic                     r_pend_valid;

  logic                     w_act_valid;
  logic                     w_accept;
  logic                     w_beat;
  logic                     w_last;
  logic                     w_act_free;
  logic [LWIDTH-1:0]        w_eff_len;
  logic [LWIDTH-1:0]        w_idx;
  logic signed [DWIDTH-1:0] w_sel;

  assign w_act_valid = (r_state == S_SHIFT);
  assign in_ready    = !r_pend_valid;
  assign w_accept    = in_valid & in_ready;
  assign w_last      = w_act_valid & (r_cnt == r_act_len - C_ONE);
  assign w_beat      = w_act_valid & out_ready;
  assign w_act_free  = !w_act_valid | (w_beat & w_last);
  assign w_eff_len   = ((in_len == '0) || (in_len > C_CORE_LEN)) ? C_CORE_LEN : in_len;
  assign w_idx       = r_act_rev ? (r_act_len - C_ONE - r_cnt) : r_cnt;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < CORE; i++) begin
      if (w_act_valid && (w_idx == LWIDTH'(i))) begin
        w_sel = r_act_data[i];
      end
    end
  end

  assign out_valid = w_act_valid;
  assign out_last  = w_last;
  assign out_data  = w_sel;
  assign busy      = w_act_valid | r_pend_valid;

  always_ff @(posedge clk) begin
    if (xrst) begin
      r_state      <= S_IDLE;
      r_act_len    <= '0;
      r_act_rev    <= 1'b0;
      r_cnt        <= '0;
      r_pend_len   <= '0;
      r_pend_rev   <= 1'b0;
      r_pend_valid <= 1'b0;
    end else if (w_act_free) begin
      // Pending always wins; in_ready is low whenever it is full, so no accept collides.
      if (r_pend_valid) begin
        r_state      <= S_SHIFT;
        r_act_len    <= r_pend_len;
        r_act_rev    <= r_pend_rev;
        r_cnt        <= '0;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_state   <= S_SHIFT;
        r_act_len <= w_eff_len;
        r_act_rev <= in_rev;
        r_cnt     <= '0;
      end else begin
        r_state <= S_IDLE;
      end
    end else begin
      if (w_accept) begin
        r_pend_len   <= w_eff_len;
        r_pend_rev   <= in_rev;
        r_pend_valid <= 1'b1;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  // Lane storage carries no reset; output is gated by the active-valid state.
  always_ff @(posedge clk) begin
    if (w_act_free && r_pend_valid) begin
      r_act_data <= r_pend_data;
    end else if (w_act_free && w_accept) begin
      r_act_data <= in_data;
    end
    if (!w_act_free && w_accept) begin
      r_pend_data <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gobou_serial_stream.sv
`default_nettype none
// Directed bench for gobou_serial_stream: hand-computed beat sequences with immediate assertions.
module tb_gobou_serial_stream;

  logic               clk;
  logic               xrst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data [15:0];
  logic [4:0]         in_len;
  logic               in_rev;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_last;
  logic               busy;

  int n_vec;
  int n_err;

  gobou_serial_stream #(.DWIDTH(16), .CORE(16)) dut (
    .clk      (clk),
    .xrst     (xrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_rev   (in_rev),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int base, input int step, input int len, input logic rev);
    for (int i = 0; i < 16; i++) in_data[i] = 16'(base + step * i);
    in_len   = 5'(len);
    in_rev   = rev;
    in_valid = 1'b1;
  endtask

  task automatic expect_beat(input string tag, input int d, input logic l);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, out_last, l);
  endtask

  int nb;
  int idx;

  initial begin
    n_vec = 0;
    n_err = 0;
    xrst = 1'b1;
    in_valid = 1'b0;
    in_len = '0;
    in_rev = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_data[i] = '0;
    tick();
    tick();
    xrst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Full vector, len=0 -> 16 lanes, forward
    load(100, 1, 0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_beat("t1", 100 + k, k == 15);
      tick();
    end
    check("t1_end_valid", out_valid, 0);
    check("t1_end_busy", busy, 0);

    // A (1..16, len4, rev) then B (-1..-16, len3, fwd), contiguous
    load(1, 1, 4, 1'b1);
    tick();
    load(-1, -1, 3, 1'b0);
    expect_beat("t2_a0", 4, 0);
    check("t2_rdy0", in_ready, 1);
    tick();
    in_valid = 1'b0;
    expect_beat("t2_a1", 3, 0);
    check("t2_rdy1", in_ready, 0);
    check("t2_busy", busy, 1);
    tick();
    expect_beat("t2_a2", 2, 0);
    check("t2_rdy2", in_ready, 0);
    tick();
    expect_beat("t2_a3", 1, 1);
    check("t2_rdy3", in_ready, 0);
    tick();
    expect_beat("t2_b0", -1, 0);
    check("t2_rdy4", in_ready, 1);
    tick();
    expect_beat("t2_b1", -2, 0);
    tick();
    expect_beat("t2_b2", -3, 1);
    tick();
    check("t2_end_valid", out_valid, 0);

    // Backpressure, len5, out_ready pattern 1,0,0,1 repeating
    load(50, 1, 5, 1'b0);
    tick();
    in_valid = 1'b0;
    nb = 0;
    idx = 0;
    for (int c = 0; c < 40 && nb < 5; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      expect_beat("t3", 50 + idx, idx == 4);
      if (out_valid && out_ready) begin
        nb++;
        idx++;
      end
      tick();
    end
    out_ready = 1'b1;
    check("t3_beats", nb, 5);
    check("t3_end_valid", out_valid, 0);

    // len=1 back to back
    load(7, 0, 1, 1'b0);
    tick();
    load(8, 0, 1, 1'b0);
    expect_beat("t4_0", 7, 1);
    tick();
    load(9, 0, 1, 1'b0);
    expect_beat("t4_1", 8, 1);
    tick();
    in_valid = 1'b0;
    expect_beat("t4_2", 9, 1);
    tick();
    check("t4_end_valid", out_valid, 0);

    // len=20 -> 16 lanes forward
    load(200, 1, 20, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_beat("t5_fwd", 200 + k, k == 15);
      tick();
    end
    check("t5_gap_valid", out_valid, 0);

    // len=16 reversed
    load(200, 1, 16, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_beat("t5_rev", 215 - k, k == 15);
      tick();
    end
    check("t5_end_valid", out_valid, 0);

    // Reset at beat 3 of 8 with pending full
    load(300, 1, 8, 1'b0);
    tick();
    load(500, 1, 4, 1'b0);
    expect_beat("t6_b0", 300, 0);
    tick();
    in_valid = 1'b0;
    expect_beat("t6_b1", 301, 0);
    tick();
    expect_beat("t6_b2", 302, 0);
    tick();
    expect_beat("t6_b3", 303, 0);
    check("t6_pend_rdy", in_ready, 0);
    xrst = 1'b1;
    tick();
    xrst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_last", out_last, 0);
    load(400, 1, 2, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_beat("t6_n0", 400, 0);
    tick();
    expect_beat("t6_n1", 401, 1);
    tick();
    check("t6_end_valid", out_valid, 0);
    check("t6_end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gobou_serial_stream.md
# gobou_serial_stream

Parametrised parallel-to-serial converter for the gobou datapath. It takes one GOBOU_CORE-lane vector per valid/ready handshake and emits the first `len` lanes one per beat on a streaming output with backpressure. Lane order is selectable per vector (forward or reversed), and an `out_last` flag marks the final lane. A one-entry pending buffer lets the next vector be accepted while the current one drains, so back-to-back vectors stream without bubbles. It sits between the core-array outputs and the serial writeback/accumulate path.

## Interface
Parameters:
- DWIDTH, 16: lane data width (signed)
- CORE, 16: lanes per input vector (≥2)
- LWIDTH, $clog2(CORE+1): width of length and count fields

Ports:
- clk  in  1  clock; all logic on rising edge
- xrst  in  1  reset, synchronous, active-high
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_data  in  DWIDTH×CORE (unpacked array [CORE-1:0], signed)  vector lanes
- in_len  in  LWIDTH  lanes to emit; 0 or >CORE means CORE
- in_rev  in  1  0: lane 0 first; 1: lane len-1 first
- out_valid  out  1  serial beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  DWIDTH signed  current lane
- out_last  out  1  current beat is last lane of its vector
- busy  out  1  active or pending vector present

## Operation
- Storage: active bank (act_data, act_len, act_rev, act_valid, cnt) and pending bank (pend_data, pend_len, pend_rev, pend_valid).
- Length normalisation at capture: eff_len = (in_len==0 || in_len>CORE) ? CORE : in_len.
- in_ready = !pend_valid (combinational from state only; never depends on in_valid).
- accept = in_valid & in_ready; beat = out_valid & out_ready.
- Active bank FSM: states IDLE (act_valid=0) and SHIFT (act_valid=1).
- act_free = !act_valid | (beat & out_last).
- At each edge, in priority order:
  - If act_free and pend_valid: active ← pending, cnt ← 0, pend_valid ← 0. No accept is possible this cycle because in_ready=0.
  - Else if act_free and accept: active ← input (bypass), cnt ← 0.
  - Else if act_free: act_valid ← 0 (→IDLE).
  - If !act_free and accept: pending ← input, pend_valid ← 1.
  - If beat and !out_last: cnt ← cnt+1.
- Output lane index = act_rev ? act_len-1-cnt : cnt.
- out_valid = act_valid; out_last = act_valid & (cnt == act_len-1).
- out_data = selected lane when act_valid, else 0.
- Data is stored unmodified: no sign extension, saturation or arithmetic.
- busy = act_valid | pend_valid.
- Held beat: while out_valid & !out_ready, out_data, out_last and cnt are stable.
- in_data is sampled only on accept; in_data changes when not accepted have no effect.

## Timing
- Reset (xrst=1 at an edge, including mid-vector): next cycle act_valid=0, pend_valid=0, cnt=0, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1. The partially emitted vector is discarded.
- Latency: accept in IDLE at edge t → first beat valid from t+1.
- Throughput: with out_ready held at 1, a vector of length L occupies exactly L beats. The next vector's first beat follows the previous out_last beat with zero bubbles, provided that vector was accepted before or on the last beat's edge.
- len=1: the first beat has out_last=1; the active bank frees on that same beat.
- Simultaneous last beat + accept with pending empty: the new vector bypasses into active; its first beat is valid the next cycle.
- Simultaneous last beat + pending full: pending moves to active, and in_ready rises the next cycle.
- Maximum occupancy: 2 vectors (active + pending). in_ready stays low until pending drains.

## Test plan
- Reset, then accept lanes 0..15 = 100..115, len=0, rev=0, out_ready=1 → 16 beats 100..115 from t+1, out_last only on 115, then out_valid=0 and busy=0.
- Accept A (lanes 1..16, len=4, rev=1) immediately followed by B (lanes -1..-16, len=3, rev=0), out_ready=1 → beats 4,3,2,1,-1,-2,-3 contiguous. in_ready low from after B's accept until A's last beat+1.
- Backpressure: len=5, out_ready toggled 1,0,0,1,… → each lane is emitted exactly once. out_data and out_last are stable while stalled, and the beat count equals 5.
- len=1 back-to-back: three vectors with lane0 = 7, 8, 9 → three consecutive beats 7, 8, 9, each with out_last=1.
- in_len=20 (>CORE) → treated as 16 lanes; in_len=16 with rev=1 → lane 15 first, lane 0 last.
- Assert xrst during beat 3 of 8 with pending full → next cycle out_valid=0, in_ready=1, busy=0. A new vector accepted after reset streams correctly from lane 0.
